// File: rtl/dual_port_ram_arbiter.sv
// Round-robin arbiter sharing one dual-port RAM among NUM_REQ requesters.
// Grants up to two non-conflicting requests per cycle and steers read data back.
module dual_port_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
  output logic [ADDR_WIDTH-1:0]          ram_addr_a,
  output logic [ADDR_WIDTH-1:0]          ram_addr_b,
  output logic [DATA_WIDTH-1:0]          ram_data_a,
  output logic [DATA_WIDTH-1:0]          ram_data_b,
  output logic                           ram_we_a,
  output logic                           ram_we_b,
  input  logic [DATA_WIDTH-1:0]          ram_q_a,
  input  logic [DATA_WIDTH-1:0]          ram_q_b
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               rd_pend_a_q, rd_pend_a_d, rd_pend_b_q, rd_pend_b_d;
  logic [IDX_W-1:0]   rd_id_a_q, rd_id_a_d, rd_id_b_q, rd_id_b_d;

  logic               grant_a, grant_b;
  logic [IDX_W-1:0]   id_a, id_b, scan_idx;
  logic [NUM_REQ-1:0] grant_vec;

  always_comb begin : unpack
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan from rr_ptr; first valid takes A, next non-conflicting valid takes B.
  always_comb begin : arbitrate
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    id_a      = '0;
    id_b      = '0;
    scan_idx  = '0;
    grant_vec = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr_q + IDX_W'(k);
      if (req_valid[scan_idx]) begin
        if (!grant_a) begin
          grant_a = 1'b1;
          id_a    = scan_idx;
        end else if (!grant_b &&
                     !((addr_arr[scan_idx] == addr_arr[id_a]) &&
                       (req_we[scan_idx] || req_we[id_a]))) begin
          grant_b = 1'b1;
          id_b    = scan_idx;
        end
      end
    end
    if (grant_a) grant_vec[id_a] = 1'b1;
    if (grant_b) grant_vec[id_b] = 1'b1;
  end

  always_comb begin : next_state
    rr_ptr_d    = rr_ptr_q;
    rd_pend_a_d = grant_a && !req_we[id_a];
    rd_pend_b_d = grant_b && !req_we[id_b];
    rd_id_a_d   = id_a;
    rd_id_b_d   = id_b;
    if (grant_b) begin
      rr_ptr_d = id_b + IDX_W'(1);
    end else if (grant_a) begin
      rr_ptr_d = id_a + IDX_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      rd_pend_a_q <= 1'b0;
      rd_pend_b_q <= 1'b0;
      rd_id_a_q   <= '0;
      rd_id_b_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rd_pend_a_q <= rd_pend_a_d;
      rd_pend_b_q <= rd_pend_b_d;
      rd_id_a_q   <= rd_id_a_d;
      rd_id_b_q   <= rd_id_b_d;
    end
  end

  // Grants and write enables are forced off while reset is held.
  always_comb begin : ram_drive
    req_ready  = reset_n ? grant_vec : '0;
    ram_addr_a = grant_a ? addr_arr[id_a]  : '0;
    ram_data_a = grant_a ? wdata_arr[id_a] : '0;
    ram_we_a   = reset_n && grant_a && req_we[id_a];
    ram_addr_b = grant_b ? addr_arr[id_b]  : '0;
    ram_data_b = grant_b ? wdata_arr[id_b] : '0;
    ram_we_b   = reset_n && grant_b && req_we[id_b];
  end

  always_comb begin : response
    rsp_valid = '0;
    rsp_rdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rd_pend_a_q && (rd_id_a_q == IDX_W'(i))) begin
        rsp_valid[i]                           = 1'b1;
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_a;
      end else if (rd_pend_b_q && (rd_id_b_q == IDX_W'(i))) begin
        rsp_valid[i]                           = 1'b1;
        rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_b;
      end
    end
  end

endmodule
